// File: rtl/fir_mac_pkg.sv
// Shared types and helpers for the time-multiplexed FIR MAC engine.
// Used by fir_mac_engine and fir_delay_line; sat_trunc serves the FIR_MAC_ROUND_SAT_EN build.
package fir_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Wrap helpers work for any tap count, not only powers of two.
    function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int unsigned ptr_wrap_dec(input int unsigned ptr, input int unsigned n);
        return (ptr == 0) ? n - 1 : ptr - 1;
    endfunction

    // Clamp a sign-extended accumulator value to the signed out_w-bit range.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] val,
                                                     input int unsigned     out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer: one write at the write pointer, one combinational read port,
// and a flush that zeroes every entry and rewinds the pointer.
module fir_delay_line
    import fir_mac_pkg::*;
#(
    parameter int N_TAPS     = 16,
    parameter int IN_WIDTH   = 8,
    parameter int ADDR_WIDTH = $clog2(N_TAPS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clr,
    input  logic                         i_wr_en,
    input  logic signed [IN_WIDTH-1:0]   i_wr_data,
    input  logic                         i_adv,
    input  logic        [ADDR_WIDTH-1:0] i_rd_addr,
    output logic signed [IN_WIDTH-1:0]   o_rd_data,
    output logic        [ADDR_WIDTH-1:0] o_wr_ptr
);

    logic signed [IN_WIDTH-1:0]   r_buf [N_TAPS];
    logic        [ADDR_WIDTH-1:0] r_wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < N_TAPS; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else begin
            if (i_wr_en) begin
                r_buf[r_wr_ptr] <= i_wr_data;
            end
            // The pointer only moves once the output of this sample has been taken.
            if (i_adv) begin
                r_wr_ptr <= ADDR_WIDTH'(ptr_wrap_inc(32'(r_wr_ptr), N_TAPS));
            end
        end
    end

    assign o_rd_data = r_buf[i_rd_addr];
    assign o_wr_ptr  = r_wr_ptr;

endmodule

// File: rtl/fir_mac_engine.sv
// Time-multiplexed FIR engine: one multiply-accumulate per clock over N_TAPS taps.
// Define FIR_MAC_ROUND_SAT_EN for round-half-up plus saturation with a sticky sat_flag.
module fir_mac_engine
    import fir_mac_pkg::*;
#(
    parameter int N_TAPS     = 16,
    parameter int IN_WIDTH   = 8,
    parameter int COEF_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(N_TAPS),
    parameter int ACC_WIDTH  = IN_WIDTH + COEF_WIDTH + ADDR_WIDTH,
    parameter int OUT_SHIFT  = 7,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         coef_wr_en,
    input  logic        [ADDR_WIDTH-1:0] coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_in,
    input  logic                         buf_clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [IN_WIDTH-1:0]   x_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  y_out,
    output logic                         busy,
    output logic                         sat_flag
);

    localparam int                    PROD_WIDTH = IN_WIDTH + COEF_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_K     = ADDR_WIDTH'(N_TAPS - 1);

    state_t                       r_state;
    state_t                       w_state_next;
    logic        [ADDR_WIDTH-1:0] r_k;
    logic        [ADDR_WIDTH-1:0] r_rd_ptr;
    logic        [ADDR_WIDTH-1:0] w_wr_ptr;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [ACC_WIDTH-1:0]  w_acc_next;
    logic signed [COEF_WIDTH-1:0] r_coef [N_TAPS];
    logic signed [IN_WIDTH-1:0]   w_rd_data;
    logic signed [PROD_WIDTH-1:0] w_prod;
    logic signed [OUT_WIDTH-1:0]  r_y;
    logic signed [OUT_WIDTH-1:0]  w_y_next;
    logic                         w_accept;
    logic                         w_last_tap;
    logic                         w_coef_wr;
    logic                         w_clr;
    logic                         w_out_fire;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid/y_out hold until taken, and in_ready never depends on in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = rst_n && !coef_wr_en && !buf_clr;
                if (in_valid && in_ready) begin
                    w_state_next = MAC;
                end
            end
            MAC: begin
                busy = 1'b1;
                if (r_k == LAST_K) begin
                    w_state_next = OUT;
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept   = in_valid && in_ready;
    assign w_last_tap = (r_state == MAC) && (r_k == LAST_K);
    assign w_coef_wr  = (r_state == IDLE) && coef_wr_en && (32'(coef_addr) < N_TAPS);
    assign w_clr      = (r_state == IDLE) && buf_clr;
    assign w_out_fire = out_valid && out_ready;

    fir_delay_line #(
        .N_TAPS     (N_TAPS),
        .IN_WIDTH   (IN_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_delay_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_wr_en   (w_accept),
        .i_wr_data (x_in),
        .i_adv     (w_out_fire),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data),
        .o_wr_ptr  (w_wr_ptr)
    );

    assign w_prod     = PROD_WIDTH'(r_coef[r_k]) * PROD_WIDTH'(w_rd_data);
    assign w_prod_ext = ACC_WIDTH'(w_prod);
    assign w_acc_next = r_acc + w_prod_ext;

`ifdef FIR_MAC_ROUND_SAT_EN
    localparam int RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [ACC_WIDTH:0] ROUND_ADD =
        (OUT_SHIFT > 0) ? ((ACC_WIDTH + 1)'(1) << RND_POS) : '0;

    logic signed [ACC_WIDTH:0] w_rnd_shifted;
    logic                      w_clip;
    logic                      r_sat;

    // One guard bit keeps the rounding add from wrapping at the accumulator extremes.
    assign w_rnd_shifted = ($signed({w_acc_next[ACC_WIDTH-1], w_acc_next}) + ROUND_ADD) >>> OUT_SHIFT;
    assign w_y_next      = OUT_WIDTH'(sat_trunc(64'(w_rnd_shifted), OUT_WIDTH));
    assign w_clip        = sat_trunc(64'(w_rnd_shifted), OUT_WIDTH) != 64'(w_rnd_shifted);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else if (w_last_tap && w_clip) begin
            r_sat <= 1'b1;
        end
    end

    assign sat_flag = r_sat;
`else
    assign w_y_next = OUT_WIDTH'(w_acc_next >>> OUT_SHIFT);
    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) begin
                r_coef[i] <= '0;
            end
            r_k      <= '0;
            r_rd_ptr <= '0;
            r_acc    <= '0;
            r_y      <= '0;
        end else begin
            if (w_coef_wr) begin
                r_coef[coef_addr] <= coef_in;
            end
            if (w_accept) begin
                r_rd_ptr <= w_wr_ptr;
                r_k      <= '0;
                r_acc    <= '0;
            end
            // Tap k pairs h[k] with the sample k steps older than the newest one.
            if (r_state == MAC) begin
                r_acc    <= w_acc_next;
                r_rd_ptr <= ADDR_WIDTH'(ptr_wrap_dec(32'(r_rd_ptr), N_TAPS));
                r_k      <= r_k + ADDR_WIDTH'(1);
            end
            if (w_last_tap) begin
                r_y <= w_y_next;
            end
        end
    end

    assign y_out = r_y;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine: a default instance (16 taps, shift 7, 8-bit out)
// and a 5-tap instance (shift 0, 16-bit out) sharing stimulus through a select line.
module tb_fir_mac_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        coef_wr_en;
    logic [3:0]  coef_addr;
    logic [7:0]  coef_in;
    logic        buf_clr;
    logic        in_valid;
    logic [7:0]  x_in;
    logic        out_ready;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    logic        a_in_ready, a_out_valid, a_busy, a_sat;
    logic [7:0]  a_y;
    logic        b_in_ready, b_out_valid, b_busy, b_sat;
    logic [15:0] b_y;
    logic        in_ready_m, out_valid_m, busy_m;
    logic [15:0] y_m;

    assign in_ready_m  = sel ? b_in_ready : a_in_ready;
    assign out_valid_m = sel ? b_out_valid : a_out_valid;
    assign busy_m      = sel ? b_busy : a_busy;
    assign y_m         = sel ? b_y : {{8{a_y[7]}}, a_y};

    fir_mac_engine u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .coef_wr_en(coef_wr_en & ~sel), .coef_addr(coef_addr), .coef_in(coef_in),
        .buf_clr(buf_clr & ~sel), .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
        .x_in(x_in), .out_valid(a_out_valid), .out_ready(out_ready), .y_out(a_y),
        .busy(a_busy), .sat_flag(a_sat)
    );

    fir_mac_engine #(.N_TAPS(5), .OUT_SHIFT(0), .OUT_WIDTH(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .coef_wr_en(coef_wr_en & sel), .coef_addr(coef_addr[2:0]), .coef_in(coef_in),
        .buf_clr(buf_clr & sel), .in_valid(in_valid & sel), .in_ready(b_in_ready),
        .x_in(x_in), .out_valid(b_out_valid), .out_ready(out_ready), .y_out(b_y),
        .busy(b_busy), .sat_flag(b_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected output of the default instance for a given accumulator value.
    function automatic logic [15:0] exp_a(input int acc);
        int         s;
        logic [7:0] t;
`ifdef FIR_MAC_ROUND_SAT_EN
        s = (acc + 64) >>> 7;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`else
        s = acc >>> 7;
`endif
        t = s[7:0];
        return {{8{t[7]}}, t};
    endfunction

    task automatic load_coef(input int addr, input int val);
        @(negedge clk);
        coef_wr_en = 1'b1;
        coef_addr  = 4'(addr);
        coef_in    = 8'(val);
        @(negedge clk);
        coef_wr_en = 1'b0;
    endtask

    task automatic flush();
        @(negedge clk);
        buf_clr = 1'b1;
        @(negedge clk);
        buf_clr = 1'b0;
    endtask

    task automatic run_sample(input int x, output logic [15:0] y, output int acc_cyc,
                              output int lat, output logic rdy_seen);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = 8'(x);
        #1;
        n = 0;
        while (!in_ready_m && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!in_ready_m) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready_m);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        acc_cyc  = cyc;
        lat      = 1;
        rdy_seen = in_ready_m;
        while (!out_valid_m && lat < 100) begin
            @(negedge clk);
            lat++;
            rdy_seen = rdy_seen | in_ready_m;
        end
        checks++;
        if (!out_valid_m) begin
            errors++;
            $display("FAIL output_timeout: out_valid=%0b required 1", out_valid_m);
        end
        y = y_m;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        checks += 10;
        if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_out_valid: got %0b want 0", a_out_valid); end
        if (a_y !== 8'h00)        begin errors++; $display("FAIL rst_a_y: got %h want 00", a_y); end
        if (a_busy !== 1'b0)      begin errors++; $display("FAIL rst_a_busy: got %0b want 0", a_busy); end
        if (a_sat !== 1'b0)       begin errors++; $display("FAIL rst_a_sat: got %0b want 0", a_sat); end
        if (a_in_ready !== 1'b0)  begin errors++; $display("FAIL rst_a_in_ready: got %0b want 0", a_in_ready); end
        if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_out_valid: got %0b want 0", b_out_valid); end
        if (b_y !== 16'h0000)     begin errors++; $display("FAIL rst_b_y: got %h want 0000", b_y); end
        if (b_busy !== 1'b0)      begin errors++; $display("FAIL rst_b_busy: got %0b want 0", b_busy); end
        if (b_sat !== 1'b0)       begin errors++; $display("FAIL rst_b_sat: got %0b want 0", b_sat); end
        if (b_in_ready !== 1'b0)  begin errors++; $display("FAIL rst_b_in_ready: got %0b want 0", b_in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %0b want 1", a_in_ready); end
    endtask

    task automatic test_impulse();
        logic [15:0] y;
        int          ac, lat;
        logic        rs;
        sel = 1'b1;
        for (int k = 0; k < 5; k++) load_coef(k, k + 1);
        flush();
        for (int i = 0; i < 10; i++) begin
            run_sample((i == 0) ? 1 : 0, y, ac, lat, rs);
            checks++;
            if (y !== 16'((i < 5) ? i + 1 : 0)) begin
                errors++;
                $display("FAIL impulse[%0d]: got %0d want %0d", i, $signed(y), (i < 5) ? i + 1 : 0);
            end
        end
    endtask

    task automatic test_random_golden();
        int          h [5];
        int          hist [5];
        int          x, exp_v, ac, lat;
        logic [15:0] y;
        logic        rs;
        sel = 1'b1;
        for (int k = 0; k < 5; k++) begin
            h[k]    = int'($urandom_range(255, 0)) - 128;
            hist[k] = 0;
            load_coef(k, h[k]);
        end
        flush();
        for (int i = 0; i < 40; i++) begin
            x = int'($urandom_range(255, 0)) - 128;
            for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = x;
            exp_v = 0;
            for (int k = 0; k < 5; k++) exp_v += h[k] * hist[k];
            run_sample(x, y, ac, lat, rs);
            checks++;
            if (y !== 16'(exp_v)) begin
                errors++;
                $display("FAIL golden_n5[%0d]: got %0d want %0d", i, $signed(y), exp_v);
            end
        end
    endtask

    task automatic test_timing();
        logic [15:0] y;
        int          ac1, ac2, lat;
        logic        rs;
        sel = 1'b0;
        out_ready = 1'b1;
        load_coef(0, 64);
        flush();
        run_sample(10, y, ac1, lat, rs);
        checks += 5;
        if (lat !== 17)     begin errors++; $display("FAIL latency: got %0d want 17", lat); end
        if (rs !== 1'b0)    begin errors++; $display("FAIL ready_in_mac_out: got %0b want 0", rs); end
        if (y !== 16'd5)    begin errors++; $display("FAIL timing_y0: got %0d want 5", $signed(y)); end
        if (a_busy !== 1'b1) begin errors++; $display("FAIL busy_in_out: got %0b want 1", a_busy); end
        if (a_sat !== 1'b0) begin errors++; $display("FAIL sat_idle: got %0b want 0", a_sat); end
        run_sample(20, y, ac2, lat, rs);
        checks += 2;
        if (ac2 - ac1 !== 18) begin errors++; $display("FAIL period: got %0d want 18", ac2 - ac1); end
        if (y !== 16'd10)     begin errors++; $display("FAIL timing_y1: got %0d want 10", $signed(y)); end
    endtask

    task automatic test_write_priority();
        logic [15:0] y;
        int          ac, lat, n;
        logic        rs;
        sel = 1'b0;
        flush();
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = 8'd100;
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        coef_wr_en = 1'b1;
        coef_addr  = 4'd0;
        coef_in    = 8'd99;
        #1;
        checks++;
        if (in_ready_m !== 1'b0) begin errors++; $display("FAIL ready_during_mac: got %0b want 0", in_ready_m); end
        @(negedge clk);
        coef_wr_en = 1'b0;
        n = 0;
        while (!out_valid_m && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (y_m !== 16'd50) begin errors++; $display("FAIL mac_write_y0: got %0d want 50", $signed(y_m)); end
        run_sample(100, y, ac, lat, rs);
        checks++;
        if (y !== 16'd50) begin errors++; $display("FAIL mac_write_ignored: got %0d want 50", $signed(y)); end
        @(negedge clk);
        coef_wr_en = 1'b1;
        coef_addr  = 4'd1;
        coef_in    = 8'd64;
        in_valid   = 1'b1;
        x_in       = 8'd100;
        #1;
        checks++;
        if (in_ready_m !== 1'b0) begin errors++; $display("FAIL ready_with_write: got %0b want 0", in_ready_m); end
        @(negedge clk);
        coef_wr_en = 1'b0;
        #1;
        checks++;
        if (in_ready_m !== 1'b1) begin errors++; $display("FAIL ready_after_write: got %0b want 1", in_ready_m); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_m && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (y_m !== 16'd100) begin errors++; $display("FAIL idle_write_applied: got %0d want 100", $signed(y_m)); end
    endtask

    task automatic test_backpressure();
        logic [15:0] y;
        int          ac, lat, n;
        logic        rs;
        sel = 1'b0;
        flush();
        out_ready = 1'b0;
        run_sample(20, y, ac, lat, rs);
        checks++;
        if (y !== 16'd10) begin errors++; $display("FAIL bp_y: got %0d want 10", $signed(y)); end
        in_valid = 1'b1;
        x_in     = 8'd40;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks += 3;
            if (out_valid_m !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, out_valid_m); end
            if (y_m !== 16'd10)       begin errors++; $display("FAIL bp_hold[%0d]: got %0d want 10", i, $signed(y_m)); end
            if (in_ready_m !== 1'b0)  begin errors++; $display("FAIL bp_ready[%0d]: got %0b want 0", i, in_ready_m); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (out_valid_m !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %0b want 0", out_valid_m); end
        if (in_ready_m !== 1'b1)  begin errors++; $display("FAIL bp_ready_after: got %0b want 1", in_ready_m); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_m && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (y_m !== 16'd30) begin errors++; $display("FAIL bp_next_y: got %0d want 30", $signed(y_m)); end
    endtask

    task automatic test_overflow();
        logic [15:0] y;
        int          ac, lat;
        logic        rs;
        sel = 1'b0;
        for (int k = 0; k < 16; k++) load_coef(k, 127);
        flush();
        for (int i = 0; i < 16; i++) run_sample(127, y, ac, lat, rs);
        checks += 2;
`ifdef FIR_MAC_ROUND_SAT_EN
        if (y !== 16'h007F) begin errors++; $display("FAIL overflow_y: got %0d want 127", $signed(y)); end
        if (a_sat !== 1'b1) begin errors++; $display("FAIL overflow_sat: got %0b want 1", a_sat); end
`else
        if (y !== 16'hFFE0) begin errors++; $display("FAIL overflow_y: got %0d want -32", $signed(y)); end
        if (a_sat !== 1'b0) begin errors++; $display("FAIL overflow_sat: got %0b want 0", a_sat); end
`endif
    endtask

    task automatic test_scaling_random();
        int          h [16];
        int          hist [16];
        int          x, acc, ac, lat;
        logic [15:0] y;
        logic        rs;
        sel = 1'b0;
        for (int k = 0; k < 16; k++) begin
            h[k]    = int'($urandom_range(255, 0)) - 128;
            hist[k] = 0;
            load_coef(k, h[k]);
        end
        flush();
        for (int i = 0; i < 12; i++) begin
            x = int'($urandom_range(255, 0)) - 128;
            for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = x;
            acc = 0;
            for (int k = 0; k < 16; k++) acc += h[k] * hist[k];
            run_sample(x, y, ac, lat, rs);
            checks++;
            if (y !== exp_a(acc)) begin
                errors++;
                $display("FAIL scaled_n16[%0d]: got %0d want %0d", i, $signed(y), $signed(exp_a(acc)));
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        logic [15:0] y;
        int          ac, lat;
        logic        rs, seen;
        sel = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = 8'd5;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (out_valid_m !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b want 0", out_valid_m); end
        if (busy_m !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %0b want 0", busy_m); end
        if (in_ready_m !== 1'b0)  begin errors++; $display("FAIL midrst_ready: got %0b want 0", in_ready_m); end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | out_valid_m;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_output: got %0b want 0", seen); end
        for (int i = 0; i < 5; i++) begin
            run_sample((i == 0) ? 1 : 0, y, ac, lat, rs);
            checks++;
            if (y !== 16'd0) begin errors++; $display("FAIL cleared_coef[%0d]: got %0d want 0", i, $signed(y)); end
        end
    endtask

    initial begin
        sel        = 1'b0;
        coef_wr_en = 1'b0;
        coef_addr  = '0;
        coef_in    = '0;
        buf_clr    = 1'b0;
        in_valid   = 1'b0;
        x_in       = '0;
        out_ready  = 1'b1;
        test_reset();
        test_impulse();
        test_random_golden();
        test_timing();
        test_write_priority();
        test_backpressure();
        test_overflow();
        test_scaling_random();
        test_reset_mid_mac();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
